// File: rtl/mul256b_loader_if.sv
// mul256b_loader_if: 32-bit operand word stream in, mul256b operand/strobe bus out.
interface mul256b_loader_if;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [255:0] datax;
  logic [255:0] datay;
  logic         update;
  logic         busy;
  logic         done;
  modport master (output clr, in_valid, in_data, input in_ready, datax, datay, update, busy, done);
  modport slave  (input clr, in_valid, in_data, output in_ready, datax, datay, update, busy, done);
endinterface

// File: rtl/mul256b_loader.sv
// mul256b_loader: collects two 256-bit operands from a word stream and sequences mul256b.
// Build option MUL256B_LD_MSW_FIRST_EN selects MSW-first word order (default LSW first).
module mul256b_loader #(
  parameter int MUL_LATENCY = 40,
  parameter int UPD_CYCLES  = 2
) (
  input  logic clk,
  input  logic rstn,
  mul256b_loader_if.slave bus
);
  localparam int LW = $clog2(MUL_LATENCY + 1);
  localparam logic [LW-1:0] UPD_LAST = LW'(UPD_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MUL_LATENCY - 1);
  localparam logic [LW-1:0] LAT_MAX  = LW'(MUL_LATENCY);
  typedef enum logic [1:0] {LOAD, UPD, WAIT, DONE} state_t;
  state_t        state;
  logic [3:0]    word_cnt;
  logic [LW-1:0] lat_cnt;
  logic [2:0]    slot;
  assign bus.in_ready = (state == LOAD) && !bus.clr;
`ifdef MUL256B_LD_MSW_FIRST_EN
  assign slot = ~word_cnt[2:0];
`else
  assign slot = word_cnt[2:0];
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= LOAD;
      word_cnt   <= '0;
      lat_cnt    <= '0;
      bus.datax  <= '0;
      bus.datay  <= '0;
      bus.update <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else if (bus.clr) begin
      state      <= LOAD;
      word_cnt   <= '0;
      lat_cnt    <= '0;
      bus.datax  <= '0;
      bus.datay  <= '0;
      bus.update <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          if (word_cnt[3]) bus.datay[{slot, 5'b0} +: 32] <= bus.in_data;
          else             bus.datax[{slot, 5'b0} +: 32] <= bus.in_data;
          word_cnt <= word_cnt + 4'd1;
          if (word_cnt == 4'd15) begin
            state      <= UPD;
            lat_cnt    <= '0;
            bus.update <= 1'b1;
            bus.busy   <= 1'b1;
          end
        end
        UPD: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (lat_cnt == UPD_LAST) begin
            state      <= WAIT;
            bus.update <= 1'b0;
          end
        end
        // lat_cnt keeps counting from the first update cycle, so done lands MUL_LATENCY cycles after it
        WAIT: begin
          lat_cnt <= (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + LW'(1);
          if (lat_cnt == LAT_LAST) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          state    <= LOAD;
          lat_cnt  <= '0;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mul256b_loader.sv
// tb_mul256b_loader: randomized operand loads checked against a word-array/timeline reference model.
module tb_mul256b_loader;
  localparam int ML = 40;
  localparam int UC = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  mul256b_loader_if bus();
  mul256b_loader #(.MUL_LATENCY(ML), .UPD_CYCLES(UC)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int e0 = 0;
  int nw = 0;
  bit active = 0;
  logic [31:0] w [16];
  logic [511:0] last_prod;
  logic [255:0] ones = '1;
  function automatic int pos(input int k);
`ifdef MUL256B_LD_MSW_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction
  function automatic logic [255:0] build(input int base);
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r = r | ({224'b0, w[base + k]} << (32 * pos(k)));
    return r;
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 16; k++) w[k] = '0;
    nw = 0;
    active = 0;
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic c, output logic acc);
    int dd;
    logic eu, ed, er;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.clr = c;
    #1;
    dd = cyc - e0 + 1;
    if (active && dd > ML + 1) active = 0;
    eu = active && dd <= UC;
    ed = active && dd == ML + 1;
    er = !active && !c;
    chk("in_ready", bus.in_ready, er);
    chk("update", bus.update, eu);
    chk("busy", bus.busy, active);
    chk("done", bus.done, ed);
    chk("datax", bus.datax, build(0));
    chk("datay", bus.datay, build(8));
    if (ed) begin
      last_prod = {256'b0, bus.datax} * {256'b0, bus.datay};
      chk("product", last_prod, {256'b0, build(0)} * {256'b0, build(8)});
    end
    acc = v && er;
    @(posedge clk);
    cyc++;
    if (c) model_clear();
    else if (acc) begin
      w[nw] = d;
      nw++;
      if (nw == 16) begin
        nw = 0;
        active = 1;
        e0 = cyc;
      end
    end
  endtask
  task automatic run_op(input logic [255:0] x, input logic [255:0] y, input int gap, input logic hold, input int clr_at);
    logic [31:0] q [16];
    logic a;
    int i = 0;
    int t = 0;
    for (int k = 0; k < 8; k++) begin
      q[k] = x[32*pos(k) +: 32];
      q[k+8] = y[32*pos(k) +: 32];
    end
    while (i < 16 && t < 3000) begin
      step($urandom_range(99) >= gap, q[i], 1'b0, a);
      if (a) i++;
      t++;
    end
    if (i < 16) chk("load_timeout", i, 16);
    for (int j = 0; j < ML + 1; j++) step(hold, $urandom, j == clr_at, a);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_update", bus.update, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_datax", bus.datax, 0);
    chk("rst_datay", bus.datay, 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic a;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.clr = 1'b0;
    model_clear();
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_datax", bus.datax, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) step(1'b0, $urandom, 1'b0, a);
    run_op(256'h1, 256'h2, 0, 1'b0, -1);
    chk("t2_datax", bus.datax, 256'h1);
    chk("t2_datay", bus.datay, 256'h2);
    chk("t2_prod", last_prod, 512'h2);
    run_op(ones, ones, 40, 1'b0, -1);
    chk("t3_prod", last_prod, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
    run_op(rnd256(), rnd256(), 0, 1'b1, -1);
    run_op(rnd256(), rnd256(), 25, 1'b1, -1);
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, 1'b0, a);
    repeat (4) step(1'b0, $urandom, 1'b0, a);
    run_op(rnd256(), rnd256(), 10, 1'b0, -1);
    run_op(rnd256(), rnd256(), 10, 1'b1, UC + 9);
    repeat (100) step(1'b0, $urandom, 1'b0, a);
    run_op(rnd256(), rnd256(), 30, 1'b0, -1);
    for (int k = 0; k < 5; k++) step(1'b1, $urandom, 1'b0, a);
    step(1'b1, $urandom, 1'b1, a);
    run_op(rnd256(), rnd256(), 0, 1'b0, -1);
`ifdef MUL256B_LD_MSW_FIRST_EN
    run_op({32'h1, 224'b0}, rnd256(), 0, 1'b0, -1);
    chk("msw_word0", w[0], 32'h1);
    chk("msw_datax", bus.datax, {32'h1, 224'b0});
`endif
    for (int k = 0; k < 16; k++) step(1'b1, $urandom, 1'b0, a);
    repeat (UC + 6) step(1'b0, $urandom, 1'b0, a);
    do_reset();
    run_op(rnd256(), rnd256(), 15, 1'b0, -1);
    repeat (2) step(1'b0, $urandom, 1'b0, a);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
